// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream -> LE 32-bit words -> instruction memory, XOR-checksum verified.
// Latency: imem write strobe one cycle after the 4th byte of a word; status flags decoded from state.
// Backpressure: rx_ready high while loading (HDR/LOAD/CHK), low once finished (DONE/ERROR).
//
// Ports:
//   SYS_clk, SYS_reset        clock, async active-low reset
//   rx_valid/rx_data/rx_ready byte stream in
//   restart                   reload request, honoured in DONE/ERROR only
//   cpu_fetch_addr            CPU fetch address, passed to imem_addr in DONE
//   imem_addr/imem_we/imem_wdata  instruction memory port
//   cpu_stall/boot_done/boot_error/words_loaded  status
module imem_boot_loader #(
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  input  logic [ADDR_W-1:0] cpu_fetch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              cpu_stall,
  output logic              boot_done,
  output logic              boot_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {HDR, LOAD, CHK, DONE, ERROR} state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt;
  logic [7:0]        hdr_lo;
  logic [23:0]       byte_buf;   // first three bytes of the word being assembled
  logic [15:0]       len;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       checksum;

  logic        acc;
  logic        fin;
  logic [15:0] len_n;
  logic [31:0] word_n;
  logic        last_word;

  assign rx_ready   = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
  assign acc        = rx_valid && rx_ready;
  assign fin        = (state_q == DONE) || (state_q == ERROR);
  assign len_n      = {rx_data, hdr_lo};
  assign word_n     = {rx_data, byte_buf};
  // words_loaded counts words already written, so +1 identifies word N-1
  assign last_word  = (words_loaded + 16'd1) == len;

  assign boot_done  = (state_q == DONE);
  assign boot_error = (state_q == ERROR);
  assign cpu_stall  = (state_q != DONE);
  assign imem_addr  = (state_q == DONE) ? cpu_fetch_addr : wr_addr;

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) state_q <= HDR;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR: begin
        if (acc && byte_cnt[0]) begin
          if (len_n == 16'd0 || len_n > DEPTH16) state_d = ERROR;
          else                                   state_d = LOAD;
        end
      end
      LOAD: begin
        if (acc && byte_cnt == 2'd3 && last_word) state_d = CHK;
      end
      CHK: begin
        if (acc && byte_cnt == 2'd3) state_d = (word_n == checksum) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (restart) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      byte_cnt     <= '0;
      hdr_lo       <= '0;
      byte_buf     <= '0;
      len          <= '0;
      word_idx     <= '0;
      wr_addr      <= '0;
      checksum     <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (fin && restart) begin
        byte_cnt     <= '0;
        word_idx     <= '0;
        wr_addr      <= '0;
        checksum     <= '0;
        words_loaded <= '0;
      end else if (acc) begin
        case (state_q)
          HDR: begin
            if (!byte_cnt[0]) begin
              hdr_lo   <= rx_data;
              byte_cnt <= 2'd1;
            end else begin
              len      <= len_n;
              byte_cnt <= 2'd0;
            end
          end
          LOAD, CHK: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt != 2'd3) begin
              byte_buf[8*byte_cnt +: 8] <= rx_data;
            end else if (state_q == LOAD) begin
              imem_we      <= 1'b1;
              imem_wdata   <= word_n;
              wr_addr      <= word_idx;
              word_idx     <= word_idx + 1'b1;
              checksum     <= checksum ^ word_n;
              words_loaded <= words_loaded + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the instruction memory.
- Receives a program image as a byte stream over a valid/ready interface and assembles it into little-endian 32-bit words.
- Writes the words sequentially into the instruction memory write port and verifies an XOR checksum.
- Owns the instruction-memory address mux: holds the CPU in stall during loading and passes the CPU fetch address through once the image is verified.

Parameters:
- DEPTH, 1000, number of 32-bit words in instruction memory; maximum legal image length.
- ADDR_W, 10, word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- SYS_clk  input  1  system clock; all state on its rising edge.
- SYS_reset  input  1  asynchronous, active-low reset.
- rx_valid  input  1  byte-stream valid.
- rx_data  input  8  byte-stream data.
- rx_ready  output  1  loader can accept a byte.
- restart  input  1  one-cycle request to reload; honoured only in DONE or ERROR.
- cpu_fetch_addr  input  ADDR_W  CPU word fetch address.
- imem_addr  output  ADDR_W  address to instruction memory.
- imem_we  output  1  instruction-memory write strobe.
- imem_wdata  output  32  write data.
- cpu_stall  output  1  CPU must hold its PC.
- boot_done  output  1  image loaded and checksum matched.
- boot_error  output  1  bad length or checksum mismatch.
- words_loaded  output  16  count of words written since the last reset or restart.

Behaviour:
- States: HDR, LOAD, CHK, DONE, ERROR.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- rx_ready = 1 in HDR, LOAD and CHK; 0 in DONE and ERROR. It is decoded combinationally from state. rx_data is ignored unless a byte is accepted.
- Reset (SYS_reset = 0, async):
  - state = HDR; imem_we = 0; imem_wdata = 0; words_loaded = 0; boot_done = 0; boot_error = 0.
  - Byte counter, word index and checksum cleared.
  - Consequently cpu_stall = 1, rx_ready = 1, imem_addr = 0.
  - Reset mid-operation abandons any partial image; memory contents are not cleared.
- HDR:
  - Accepts 2 bytes forming length N (first byte = N[7:0], second = N[15:8]).
  - On the edge accepting the second byte: if N == 0 or N > DEPTH, go to ERROR; otherwise go to LOAD.
- LOAD:
  - A 2-bit byte counter assembles each word little-endian (first byte → bits [7:0]).
  - On the edge accepting the 4th byte of a word:
    - imem_wdata <= assembled word; imem_we <= 1 for exactly one cycle.
    - Internal write address <= word index; word index increments.
    - checksum <= checksum ^ word; words_loaded increments.
  - When the word just written is word N-1, the state goes to CHK on the same edge.
  - Back-to-back words are supported: imem_we may be high on consecutive cycles only if bytes arrive at least every cycle (minimum 4 cycles per word, so in practice it is not).
- CHK:
  - Accepts 4 bytes, little-endian, as the expected checksum.
  - On the 4th byte: match go to DONE, mismatch go to ERROR.
- DONE:
  - boot_done = 1; cpu_stall = 0; imem_addr = cpu_fetch_addr (combinational pass-through); imem_we = 0.
- ERROR:
  - boot_error = 1; cpu_stall = 1; imem_we = 0.
  - The state is held until restart or reset.
- imem_addr outside DONE equals the registered write address of the current or last write.
- restart:
  - In DONE or ERROR: next state HDR; boot_done, boot_error, words_loaded, checksum, counters and write address cleared; cpu_stall returns to 1 on the same edge.
  - In HDR, LOAD or CHK: ignored.
- A gap (rx_valid = 0) at any point only pauses progress; there is no timeout.
- boot_done and boot_error are never both 1.

Test Plan:
1. Reset: hold SYS_reset = 0 → rx_ready = 1, cpu_stall = 1, imem_we = 0, boot_done = 0, boot_error = 0, words_loaded = 0, imem_addr = 0.
2. Nominal load:
   - Stimulus: bytes 02 00 | 13 00 00 00 | 93 00 50 00 | 80 00 50 00 with rx_valid continuous.
   - Required: imem_we pulses with (addr 0, data 0x00000013) then (addr 1, data 0x00500093); words_loaded = 2; boot_done = 1, cpu_stall = 0, rx_ready = 0.
   - Then cpu_fetch_addr = 5 → imem_addr = 5 the same cycle.
3. Checksum fault: same image with checksum bytes 81 00 50 00 → both words written; boot_error = 1, boot_done = 0, cpu_stall = 1, rx_ready = 0.
4. Bad length: header 00 00 → ERROR after the 2nd byte, no imem_we. After restart, header E9 03 (N = 1001) → ERROR. After restart, header E8 03 (N = 1000) → LOAD.
5. Flow gaps plus restart:
   - Stimulus: test 2 image with 1–3 idle cycles randomly inserted between bytes.
   - Required: identical writes and DONE. Then pulse restart → HDR, cpu_stall = 1, words_loaded = 0; reload with a 1-word image (01 00 | 37 01 00 00 | 37 01 00 00) → DONE, write at addr 0.
6. Async reset mid-LOAD: assert SYS_reset = 0 between clock edges after the 6th byte of test 2 → outputs take reset values immediately. After release, a full test 2 stream → nominal completion.
